// File: rtl/seq_detector_prog.sv
// -----------------------------------------------------------------------------
// seq_detector_prog
//
// Runtime-programmable serial sequence detector. A pattern of 1..MAX_LEN bits
// and its length are loaded at run time. The detector then watches a
// qualified serial bit stream and raises a registered one-cycle detect pulse
// each time the most recent bits equal the pattern. Matches can either
// overlap, so that the tail of one match counts toward the next, or restart
// from scratch after each match. A saturating counter tallies matches.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in_valid     in_bit is consumed this cycle
//   in_bit       serial data bit
//   cfg_load     load cfg_pattern / cfg_len / cfg_overlap this cycle
//   cfg_pattern  pattern; bit [cfg_len-1] is received first, bit [0] last
//   cfg_len      pattern length, legal range 1..MAX_LEN
//   cfg_overlap  1 = overlapping matches, 0 = restart after a match
//   clr_count    synchronous clear of match_count
//   detect       high for one cycle after the bit that completes a match
//   match_count  matches since reset/clear, saturating at all-ones
//   armed        high while a valid configuration is loaded (RUN state)
//   cfg_err      sticky flag for an illegal length, cleared by a legal load
// -----------------------------------------------------------------------------
module seq_detector_prog #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    output logic               detect,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed,
    output logic               cfg_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   fill_q;
    logic               overlap_q;
    logic               detect_q;
    logic               armed_q;
    logic               cfgErr_q;
    logic [CNT_W-1:0]   count_q;

    logic [MAX_LEN-1:0] hist_d;
    logic [LEN_W-1:0]   fill_d;
    logic [CNT_W-1:0]   count_d;
    logic [MAX_LEN:0]   maskWide;
    logic [MAX_LEN-1:0] lenMask;
    logic               cfgLegal;
    logic               match;

    // Candidate history after shifting in the current bit, plus the fill
    // level that says how many of those history bits are genuinely received
    // (fill saturates so it never wraps on long streams). A match needs at
    // least len real bits and equality on the low len bits only; pattern
    // bits above len are masked away so stale upper bits never interfere.
    // The mask is built one bit wider so len == MAX_LEN yields all ones.
    always_comb begin
        hist_d   = {hist_q[MAX_LEN-2:0], in_bit};
        fill_d   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
        maskWide = ((MAX_LEN + 1)'(1) << len_q) - (MAX_LEN + 1)'(1);
        lenMask  = maskWide[MAX_LEN-1:0];
        cfgLegal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        match    = (state_q == RUN) && in_valid && !cfg_load
                   && (fill_d >= len_q)
                   && (((hist_d ^ pattern_q) & lenMask) == '0);
    end

    // Counter next value: a clear that coincides with a match still
    // records that match, and the count sticks at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clr_count) begin
            count_d = match ? CNT_W'(1) : '0;
        end else if (match && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Main FSM. A configuration load takes priority over the data bit of the
    // same cycle. An illegal length drops back to IDLE and flags the error.
    // In RUN, each valid bit shifts in; after a non-overlapping match the fill
    // restarts at zero so len fresh bits are required before the next match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            detect_q  <= 1'b0;
            armed_q   <= 1'b0;
            cfgErr_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            detect_q <= 1'b0;
            count_q  <= count_d;
            if (cfg_load) begin
                hist_q <= '0;
                fill_q <= '0;
                if (cfgLegal) begin
                    state_q   <= RUN;
                    pattern_q <= cfg_pattern;
                    len_q     <= cfg_len;
                    overlap_q <= cfg_overlap;
                    armed_q   <= 1'b1;
                    cfgErr_q  <= 1'b0;
                end else begin
                    state_q  <= IDLE;
                    armed_q  <= 1'b0;
                    cfgErr_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    RUN: begin
                        if (in_valid) begin
                            hist_q   <= hist_d;
                            fill_q   <= (match && !overlap_q) ? '0 : fill_d;
                            detect_q <= match;
                        end
                    end
                    default: begin
                        detect_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign detect      = detect_q;
    assign match_count = count_q;
    assign armed       = armed_q;
    assign cfg_err     = cfgErr_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_prog
//
// Drives two detector instances (8-bit and 2-bit match counters) from the
// same inputs. A table of directed vectors covers the basic scenarios, a few
// hand-written sequences cover saturation and asynchronous reset, and a
// randomized phase compares against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               inValid;
    logic               inBit;
    logic               cfgLoad;
    logic [MAX_LEN-1:0] cfgPattern;
    logic [LEN_W-1:0]   cfgLen;
    logic               cfgOverlap;
    logic               clrCount;
    logic               detect, detectSmall;
    logic [7:0]         matchCount;
    logic [1:0]         matchCountSmall;
    logic               armed, armedSmall;
    logic               cfgErr, cfgErrSmall;

    int checks = 0;
    int errors = 0;

    // Reference model state: the bits received since the last restart
    int       mArmed;
    int       mErr;
    int       mLen;
    int       mOverlap;
    bit [7:0] mPattern;
    bit       mBits[$];
    int       mCount;
    bit       mDetect;

    typedef struct {
        logic       v;
        logic       b;
        logic       ld;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ov;
        logic       clr;
        logic       expDet;
        int         expCnt;
        logic       expArm;
        logic       expErr;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_bit(inBit),
        .cfg_load(cfgLoad), .cfg_pattern(cfgPattern), .cfg_len(cfgLen),
        .cfg_overlap(cfgOverlap), .clr_count(clrCount), .detect(detect),
        .match_count(matchCount), .armed(armed), .cfg_err(cfgErr)
    );

    seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dutSmall (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_bit(inBit),
        .cfg_load(cfgLoad), .cfg_pattern(cfgPattern), .cfg_len(cfgLen),
        .cfg_overlap(cfgOverlap), .clr_count(clrCount), .detect(detectSmall),
        .match_count(matchCountSmall), .armed(armedSmall), .cfg_err(cfgErrSmall)
    );

    function automatic int sat(input int value, input int width);
        int maxVal;
        maxVal = (1 << width) - 1;
        return (value > maxVal) ? maxVal : value;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        mArmed = 0; mErr = 0; mLen = 0; mOverlap = 0; mPattern = '0;
        mBits.delete(); mCount = 0; mDetect = 1'b0;
    endtask

    // Applies the rules one clock edge at a time using the pre-edge inputs
    task automatic modelStep();
        bit hit;
        hit = 1'b0;
        if (cfgLoad) begin
            mBits.delete();
            if (cfgLen >= 1 && cfgLen <= MAX_LEN) begin
                mArmed = 1; mErr = 0; mLen = int'(cfgLen);
                mPattern = cfgPattern; mOverlap = int'(cfgOverlap);
            end else begin
                mArmed = 0; mErr = 1;
            end
        end else if (mArmed != 0 && inValid) begin
            mBits.push_back(inBit);
            if (mBits.size() >= mLen) begin
                hit = 1'b1;
                for (int i = 0; i < mLen; i++)
                    if (mBits[mBits.size() - 1 - i] != mPattern[i]) hit = 1'b0;
            end
            if (hit && mOverlap == 0) mBits.delete();
            if (mBits.size() > MAX_LEN) void'(mBits.pop_front());
        end
        mDetect = hit;
        if (clrCount) mCount = hit ? 1 : 0;
        else if (hit) mCount++;
    endtask

    task automatic applyStimulus(input logic v, input logic b, input logic ld,
                                 input logic [7:0] pat, input logic [3:0] len,
                                 input logic ov, input logic clr);
        inValid = v; inBit = b; cfgLoad = ld; cfgPattern = pat;
        cfgLen = len; cfgOverlap = ov; clrCount = clr;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAgainstModel(input string tag);
        checkOutput({tag, " detect"}, detect, mDetect);
        checkOutput({tag, " detectSmall"}, detectSmall, mDetect);
        checkOutput({tag, " count"}, matchCount, sat(mCount, 8));
        checkOutput({tag, " countSmall"}, matchCountSmall, sat(mCount, 2));
        checkOutput({tag, " armed"}, armed, mArmed);
        checkOutput({tag, " cfgErr"}, cfgErr, mErr);
    endtask

    function automatic void addRow(input logic v, input logic b, input logic ld,
                                   input logic [7:0] pat, input logic [3:0] len,
                                   input logic ov, input logic clr, input logic det,
                                   input int cnt, input logic arm, input logic err);
        vecs.push_back('{v, b, ld, pat, len, ov, clr, det, cnt, arm, err});
    endfunction

    // Bit row: valid data bit, no configuration activity
    function automatic void addBit(input logic v, input logic b, input logic det,
                                   input int cnt, input logic arm, input logic err);
        addRow(v, b, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, det, cnt, arm, err);
    endfunction

    initial begin
        reset = 1'b1;
        inValid = 1'b0; inBit = 1'b0; cfgLoad = 1'b0; cfgPattern = '0;
        cfgLen = '0; cfgOverlap = 1'b0; clrCount = 1'b0;
        modelReset();

        // 1011 overlapping; load carries in_valid to show load wins
        addRow(1, 1, 1, 8'h0B, 4'd4, 1, 0, 0, 0, 1, 0);
        addBit(1, 1, 0, 0, 1, 0); addBit(1, 0, 0, 0, 1, 0); addBit(1, 1, 0, 0, 1, 0);
        addBit(1, 1, 1, 1, 1, 0); addBit(1, 0, 0, 1, 1, 0); addBit(1, 1, 0, 1, 1, 0);
        addBit(1, 1, 1, 2, 1, 0);
        // 1011 non-overlapping
        addRow(0, 0, 1, 8'h0B, 4'd4, 0, 1, 0, 0, 1, 0);
        addBit(1, 1, 0, 0, 1, 0); addBit(1, 0, 0, 0, 1, 0); addBit(1, 1, 0, 0, 1, 0);
        addBit(1, 1, 1, 1, 1, 0); addBit(1, 0, 0, 1, 1, 0); addBit(1, 1, 0, 1, 1, 0);
        addBit(1, 1, 0, 1, 1, 0);
        // 111 overlapping, five ones
        addRow(0, 0, 1, 8'h07, 4'd3, 1, 1, 0, 0, 1, 0);
        addBit(1, 1, 0, 0, 1, 0); addBit(1, 1, 0, 0, 1, 0); addBit(1, 1, 1, 1, 1, 0);
        addBit(1, 1, 1, 2, 1, 0); addBit(1, 1, 1, 3, 1, 0);
        // 111 non-overlapping, five ones
        addRow(0, 0, 1, 8'h07, 4'd3, 0, 1, 0, 0, 1, 0);
        addBit(1, 1, 0, 0, 1, 0); addBit(1, 1, 0, 0, 1, 0); addBit(1, 1, 1, 1, 1, 0);
        addBit(1, 1, 0, 1, 1, 0); addBit(1, 1, 0, 1, 1, 0);
        // 1011 with two idle cycles between valid bits
        addRow(0, 0, 1, 8'h0B, 4'd4, 1, 1, 0, 0, 1, 0);
        addBit(1, 1, 0, 0, 1, 0); addBit(0, 1, 0, 0, 1, 0); addBit(0, 0, 0, 0, 1, 0);
        addBit(1, 0, 0, 0, 1, 0); addBit(0, 1, 0, 0, 1, 0); addBit(0, 1, 0, 0, 1, 0);
        addBit(1, 1, 0, 0, 1, 0); addBit(0, 1, 0, 0, 1, 0); addBit(0, 0, 0, 0, 1, 0);
        addBit(1, 1, 1, 1, 1, 0); addBit(0, 1, 0, 1, 1, 0);
        // illegal lengths: zero, then above MAX_LEN
        addRow(0, 0, 1, 8'hFF, 4'd0, 1, 0, 0, 1, 0, 1);
        addBit(1, 1, 0, 1, 0, 1); addBit(1, 0, 0, 1, 0, 1); addBit(1, 1, 0, 1, 0, 1);
        addBit(1, 1, 0, 1, 0, 1);
        addRow(0, 0, 1, 8'hFF, 4'd9, 1, 0, 0, 1, 0, 1);
        addBit(1, 1, 0, 1, 0, 1);
        // legal 01 with junk in unused pattern bits
        addRow(0, 0, 1, 8'hFD, 4'd2, 1, 0, 0, 1, 1, 0);
        addBit(1, 0, 0, 1, 1, 0); addBit(1, 1, 1, 2, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        checkAgainstModel("reset");
        checkOutput("reset detect const", detect, 1'b0);
        checkOutput("reset count const", matchCount, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].v, vecs[i].b, vecs[i].ld, vecs[i].pat,
                          vecs[i].len, vecs[i].ov, vecs[i].clr);
            checkOutput($sformatf("vec%0d detect", i), detect, vecs[i].expDet);
            checkOutput($sformatf("vec%0d detectSmall", i), detectSmall, vecs[i].expDet);
            checkOutput($sformatf("vec%0d count", i), matchCount, vecs[i].expCnt);
            checkOutput($sformatf("vec%0d countSmall", i), matchCountSmall, sat(vecs[i].expCnt, 2));
            checkOutput($sformatf("vec%0d armed", i), armed, vecs[i].expArm);
            checkOutput($sformatf("vec%0d cfgErr", i), cfgErr, vecs[i].expErr);
        end

        // Saturation: single-bit pattern 1 matches on every 1
        applyStimulus(0, 0, 1, 8'h01, 4'd1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 0, 8'h00, 4'd0, 0, 0);
            checkAgainstModel($sformatf("sat%0d", i));
        end
        checkOutput("sat small count", matchCountSmall, 2'd3);
        checkOutput("sat wide count", matchCount, 8'd5);
        applyStimulus(1, 1, 0, 8'h00, 4'd0, 0, 1);
        checkOutput("clr with match small", matchCountSmall, 2'd1);
        checkOutput("clr with match wide", matchCount, 8'd1);
        checkOutput("clr with match detect", detect, 1'b1);
        applyStimulus(0, 0, 0, 8'h00, 4'd0, 0, 1);
        checkOutput("clr alone", matchCount, 8'd0);

        // Asynchronous reset mid-pattern
        applyStimulus(0, 0, 1, 8'h0B, 4'd4, 1, 0);
        applyStimulus(1, 1, 0, 8'h00, 4'd0, 0, 0);
        applyStimulus(1, 0, 0, 8'h00, 4'd0, 0, 0);
        applyStimulus(1, 1, 0, 8'h00, 4'd0, 0, 0);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset armed", armed, 1'b0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1, 1, 0, 8'h00, 4'd0, 0, 0);
        checkOutput("post reset detect", detect, 1'b0);
        checkAgainstModel("post reset");
        applyStimulus(0, 0, 1, 8'h0B, 4'd4, 1, 0);
        applyStimulus(1, 1, 0, 8'h00, 4'd0, 0, 0);
        checkOutput("post reload detect", detect, 1'b0);

        // Randomized phase against the reference model
        for (int i = 0; i < 800; i++) begin
            logic       ld;
            logic [3:0] len;
            ld  = ($urandom_range(0, 24) == 0);
            len = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(1, 4));
            applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom), ld,
                          8'($urandom), len, 1'($urandom),
                          ($urandom_range(0, 29) == 0));
            checkAgainstModel($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
- Runtime-programmable serial sequence detector; successor to the fixed 5-state Moore detector.
- Pattern value and length are loaded at run time, up to MAX_LEN bits.
- Selectable overlapping or non-overlapping detection, input valid qualifier, registered Moore-style detect pulse, saturating match counter.
- Sits on a serial bit stream ahead of framing/control logic; one bit consumed per in_valid cycle.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32)
CNT_W, 8, width of match counter
LEN_W, $clog2(MAX_LEN+1), width of cfg_len (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  in_bit is consumed this cycle
in_bit  input  1  serial data bit
cfg_load  input  1  load cfg_pattern/cfg_len/cfg_overlap this cycle
cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is first received, bit [0] last
cfg_len  input  LEN_W  pattern length, legal 1..MAX_LEN
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = restart after a match
clr_count  input  1  synchronous clear of match_count
detect  output  1  registered; high one cycle after the bit completing a match
match_count  output  CNT_W  number of matches since reset/clear, saturating
armed  output  1  high in RUN state (valid config loaded)
cfg_err  output  1  sticky; set by load with illegal cfg_len, cleared by next legal load

Behaviour:
- Reset (async): state=IDLE, history=0, fill=0, detect=0, match_count=0, armed=0, cfg_err=0, stored pattern/len/overlap=0.
- States: IDLE (no valid config; bits ignored, detect held 0) and RUN (detecting).
- cfg_load with cfg_len in 1..MAX_LEN: latch config, clear history and fill, cfg_err<=0, state<=RUN. Applies from any state. detect<=0 the same edge.
- cfg_load with cfg_len=0 or >MAX_LEN: state<=IDLE, cfg_err<=1, history/fill cleared, detect<=0.
- cfg_load and in_valid in the same cycle: load wins, in_bit discarded.
- RUN, in_valid=1: next_hist={hist[MAX_LEN-2:0],in_bit}; next_fill=min(fill+1,MAX_LEN).
- Match condition: next_fill>=len and next_hist[len-1:0]==pattern[len-1:0].
- detect <= match. Asserted only in the cycle after the completing edge. Consecutive matches give consecutive detect cycles.
- On match with overlap=1: history/fill kept, so suffix bits count toward the next match.
- On match with overlap=0: fill<=0. The next match needs len fresh bits after the match.
- in_valid=0: history, fill and state unchanged; detect<=0.
- match_count: +1 per match, saturates at 2^CNT_W-1 with no wrap.
- clr_count alone: count<=0.
- clr_count and match in the same cycle: count<=1.
- Reset mid-stream: all state lost immediately; a pattern partially received before reset never matches.
- Latency: in_bit at edge k completes a match -> detect=1 between edges k and k+1.
- match_count updates at edge k as well.

Test Plan:
- Reset, then detect sequence 1011 (len=4, overlap=1) on stream 1,0,1,1,0,1,1 -> detect after bits 4 and 7; match_count=2; armed=1.
- Same pattern, overlap=0, stream 1,0,1,1,0,1,1 -> detect after bit 4 only; match_count=1.
- Pattern 111, len=3, overlap=1, five consecutive 1s -> detect high 3 consecutive cycles (after bits 3,4,5); overlap=0 -> detect after bit 3 only.
- Stream 1,0,1,1 with in_valid gaps of 2 idle cycles between bits -> single detect after the 4th valid bit; detect=0 during idles.
- cfg_len=0 load -> cfg_err=1, armed=0, no detects on any stream; then legal load (pattern 01, len=2) -> cfg_err=0, stream 0,1 detects.
- CNT_W=2, 5 matches -> match_count saturates at 3; clr_count coincident with a 6th match -> match_count=1; async reset asserted after bits 1,0,1 of 1011 -> the next 1 gives no detect.
